// File: rtl/uart_tx_if.sv
// Host-side bundle for the UART transmitter: byte/load/send controls in,
// serial line and status pulses out. Clock and reset stay plain ports.
interface uart_tx_if;
    logic [7:0] tx_in;
    logic       load_data;
    logic       send_data;
    logic       dataout_tx;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overrun;

    // Host control FSM side
    modport master (
        output tx_in,
        output load_data,
        output send_data,
        input  dataout_tx,
        input  tx_busy,
        input  tx_done,
        input  tx_overrun
    );

    // Transmitter side
    modport slave (
        input  tx_in,
        input  load_data,
        input  send_data,
        output dataout_tx,
        output tx_busy,
        output tx_done,
        output tx_overrun
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start(0), 8 data bits LSB first, parity, stop(1).
// Each serial bit lasts CLKS_PER_BIT clk_tx cycles. The parity bit is
// computed when the byte is loaded and travels with it. Dropping send_data
// mid-frame aborts the frame with the line returned high and no tx_done.
module uart_tx #(
    parameter logic VERIFY_EVEN  = 1'b1,
    parameter logic VERIFY_ODD   = 1'b0,
    parameter int   CLKS_PER_BIT = 16
) (
    input  logic      clk_tx,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity slot value for a byte; even takes precedence, neither selected drives 1.
    function automatic logic parity_f(input logic [7:0] d);
        logic p;
        if (VERIFY_EVEN) begin
            p = ^d;
        end else if (VERIFY_ODD) begin
            p = ~^d;
        end else begin
            p = 1'b1;
        end
        return p;
    endfunction

    state_t        state_q;
    logic [7:0]    hold_q;
    logic          hold_par_q;
    logic          pending_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_idx_q;
    logic          dataout_q;
    logic          busy_q;
    logic          done_q;
    logic          overrun_q;

    logic          cnt_wrap_s;
    logic [2:0]    bit_nxt_s;
    logic          start_s;

    assign cnt_wrap_s = (clk_cnt_q == CNT_LAST);
    assign bit_nxt_s  = bit_idx_q + 3'd1;
    assign start_s    = (pending_q | bus.load_data) & bus.send_data;

    assign bus.dataout_tx = dataout_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_overrun = overrun_q;

    // Frame FSM: bit timing, serialisation, abort, overrun, registered outputs.
    always_ff @(posedge clk_tx or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= 8'h00;
            hold_par_q <= 1'b0;
            pending_q  <= 1'b0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            dataout_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= bus.load_data & busy_q;

            if ((state_q != IDLE) && !bus.send_data) begin
                // abort: straight back to idle, nothing kept, no completion pulse
                state_q   <= IDLE;
                dataout_q <= 1'b1;
                busy_q    <= 1'b0;
                clk_cnt_q <= '0;
                bit_idx_q <= 3'd0;
                pending_q <= 1'b0;
            end else begin
                if (state_q != IDLE) begin
                    clk_cnt_q <= cnt_wrap_s ? '0 : clk_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    clk_cnt_q <= '0;
                end

                case (state_q)
                    IDLE: begin
                        dataout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        bit_idx_q <= 3'd0;
                        if (bus.load_data) begin
                            hold_q     <= bus.tx_in;
                            hold_par_q <= parity_f(bus.tx_in);
                        end else begin
                            hold_q     <= hold_q;
                            hold_par_q <= hold_par_q;
                        end
                        if (start_s) begin
                            // a byte loaded this cycle wins over the held one
                            state_q   <= START;
                            busy_q    <= 1'b1;
                            pending_q <= 1'b0;
                            dataout_q <= 1'b0;
                            shift_q   <= bus.load_data ? bus.tx_in : hold_q;
                            par_q     <= bus.load_data ? parity_f(bus.tx_in) : hold_par_q;
                        end else if (bus.load_data) begin
                            pending_q <= 1'b1;
                        end else begin
                            pending_q <= pending_q;
                        end
                    end
                    START: begin
                        if (cnt_wrap_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= 3'd0;
                            dataout_q <= shift_q[0];
                        end else begin
                            dataout_q <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (cnt_wrap_s) begin
                            if (bit_idx_q == 3'd7) begin
                                state_q   <= PARITY;
                                dataout_q <= par_q;
                            end else begin
                                bit_idx_q <= bit_nxt_s;
                                dataout_q <= shift_q[bit_nxt_s];
                            end
                        end else begin
                            dataout_q <= shift_q[bit_idx_q];
                        end
                    end
                    PARITY: begin
                        if (cnt_wrap_s) begin
                            state_q   <= STOP;
                            dataout_q <= 1'b1;
                        end else begin
                            dataout_q <= par_q;
                        end
                    end
                    STOP: begin
                        dataout_q <= 1'b1;
                        if (cnt_wrap_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        dataout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        clk_cnt_q <= '0;
                        bit_idx_q <= 3'd0;
                        pending_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: an even-parity instance (sel 0) and an odd-parity
// instance (sel 1). Expected frames go into a queue when a byte is driven;
// a serial decoder samples mid-bit and pops/compares each received frame.
module tb_uart_tx;

    logic clk_tx = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   failures = 0;

    logic [10:0] exp_q[$];

    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    uart_tx #(.VERIFY_EVEN(1'b1), .VERIFY_ODD(1'b0), .CLKS_PER_BIT(16)) dut_even (
        .clk_tx (clk_tx),
        .rst_n  (rst_n),
        .bus    (bus1)
    );

    uart_tx #(.VERIFY_EVEN(1'b0), .VERIFY_ODD(1'b1), .CLKS_PER_BIT(16)) dut_odd (
        .clk_tx (clk_tx),
        .rst_n  (rst_n),
        .bus    (bus2)
    );

    always #5 clk_tx = ~clk_tx;

    always @(posedge clk_tx) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic drive(input int sel, input logic [7:0] d, input logic ld, input logic sd);
        if (sel == 1) begin
            bus2.tx_in = d; bus2.load_data = ld; bus2.send_data = sd;
        end else begin
            bus1.tx_in = d; bus1.load_data = ld; bus1.send_data = sd;
        end
    endtask

    function automatic logic line(input int sel);
        return (sel == 1) ? bus2.dataout_tx : bus1.dataout_tx;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 1) ? bus2.tx_done : bus1.tx_done;
    endfunction

    // frame bit 0 = start, bits 8:1 = data LSB first, bit 9 = parity, bit 10 = stop
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit odd);
        logic p;
        p = odd ? ~^d : ^d;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Waits (bounded) for a start bit, samples 11 bits mid-bit, then waits for tx_done.
    task automatic recv_frame(input int sel, output logic [10:0] bits,
                              output int start_c, output int done_c);
        int k;
        bits = 11'h7FF;
        start_c = -1;
        done_c = -1;
        k = 0;
        while (line(sel) !== 1'b0 && k < 400) begin tick(); k++; end
        if (line(sel) === 1'b0) begin
            start_c = cyc;
            repeat (8) tick();
            bits[0] = line(sel);
            for (int b = 1; b < 11; b++) begin
                repeat (16) tick();
                bits[b] = line(sel);
            end
            k = 0;
            while (done_of(sel) !== 1'b1 && k < 20) begin tick(); k++; end
            if (done_of(sel) === 1'b1) done_c = cyc;
        end
    endtask

    task automatic check_frame(input string name, input logic [10:0] got);
        logic [10:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s frame: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: line=%b busy=%b expected line=1 busy=0", bus1.dataout_tx, bus1.tx_busy);
        end
        checks++;
        if (bus1.tx_done !== 1'b0 || bus1.tx_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: done=%b overrun=%b expected 0 0", bus1.tx_done, bus1.tx_overrun);
        end
        checks++;
        if (bus2.dataout_tx !== 1'b1 || bus2.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_odd: line=%b busy=%b expected line=1 busy=0", bus2.dataout_tx, bus2.tx_busy);
        end
    endtask

    task automatic test_even_parity();
        logic [10:0] bits;
        int c0, s, d;
        exp_q.push_back(make_frame(8'hA5, 1'b0));
        c0 = cyc;
        drive(0, 8'hA5, 1'b1, 1'b1);
        tick();
        drive(0, 8'hA5, 1'b0, 1'b1);
        recv_frame(0, bits, s, d);
        check_frame("even_A5", bits);
        checks++;
        if (s - c0 !== 1) begin
            failures++;
            $display("FAIL even_latency: start after %0d cycles expected 1", s - c0);
        end
        checks++;
        if (d - c0 !== 177) begin
            failures++;
            $display("FAIL even_done_time: done after %0d cycles expected 177", d - c0);
        end
        tick();
        checks++;
        if (bus1.tx_done !== 1'b0 || bus1.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL even_done_width: done=%b busy=%b expected 0 0", bus1.tx_done, bus1.tx_busy);
        end
    endtask

    task automatic test_odd_parity();
        logic [10:0] bits;
        int s, d;
        exp_q.push_back(make_frame(8'h01, 1'b1));
        drive(1, 8'h01, 1'b1, 1'b1);
        tick();
        drive(1, 8'h01, 1'b0, 1'b1);
        recv_frame(1, bits, s, d);
        check_frame("odd_01", bits);
        checks++;
        if (bits[9] !== 1'b0) begin
            failures++;
            $display("FAIL odd_parity_bit: got %b expected 0", bits[9]);
        end
        exp_q.push_back(make_frame(8'h01, 1'b0));
        drive(0, 8'h01, 1'b1, 1'b1);
        tick();
        drive(0, 8'h01, 1'b0, 1'b1);
        recv_frame(0, bits, s, d);
        check_frame("even_01", bits);
        checks++;
        if (bits[9] !== 1'b1) begin
            failures++;
            $display("FAIL even_parity_bit: got %b expected 1", bits[9]);
        end
        tick();
    endtask

    task automatic test_deferred_send();
        logic [10:0] bits;
        int c1, s, d;
        bit bad;
        exp_q.push_back(make_frame(8'h3C, 1'b0));
        drive(0, 8'h3C, 1'b1, 1'b0);
        tick();
        drive(0, 8'h3C, 1'b0, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL deferred_hold: line left idle before send_data, expected idle high");
        end
        c1 = cyc;
        drive(0, 8'h3C, 1'b0, 1'b1);
        tick();
        recv_frame(0, bits, s, d);
        check_frame("deferred_3C", bits);
        checks++;
        if (s - c1 !== 1) begin
            failures++;
            $display("FAIL deferred_latency: start after %0d cycles expected 1", s - c1);
        end
        checks++;
        if (d - c1 !== 177) begin
            failures++;
            $display("FAIL deferred_done_time: done after %0d cycles expected 177", d - c1);
        end
        tick();
    endtask

    task automatic test_overrun();
        logic [10:0] bits;
        int c0, s, d;
        bit bad;
        exp_q.push_back(make_frame(8'h96, 1'b0));
        c0 = cyc;
        drive(0, 8'h96, 1'b1, 1'b1);
        tick();
        drive(0, 8'h96, 1'b0, 1'b1);
        fork
            recv_frame(0, bits, s, d);
            begin
                while (cyc - c0 < 40) tick();
                drive(0, 8'hFF, 1'b1, 1'b1);
                tick();
                checks++;
                if (bus1.tx_overrun !== 1'b1) begin
                    failures++;
                    $display("FAIL overrun_pulse: got %b expected 1", bus1.tx_overrun);
                end
                drive(0, 8'hFF, 1'b0, 1'b1);
                tick();
                checks++;
                if (bus1.tx_overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_width: got %b expected 0", bus1.tx_overrun);
                end
            end
        join
        check_frame("overrun_96", bits);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL overrun_ignored: a frame started from the overrun byte, expected idle");
        end
    endtask

    task automatic test_abort();
        int c0;
        bit bad;
        c0 = cyc;
        drive(0, 8'hC3, 1'b1, 1'b1);
        tick();
        drive(0, 8'hC3, 1'b0, 1'b1);
        while (cyc - c0 < 60) tick();
        drive(0, 8'hC3, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: line=%b busy=%b expected line=1 busy=0", bus1.dataout_tx, bus1.tx_busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus1.tx_done !== 1'b0 || bus1.dataout_tx !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_no_done: tx_done or line activity after abort, expected none");
        end
        drive(0, 8'hC3, 1'b0, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_pending_clear: frame restarted after abort, expected idle");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int rx_start [3];
        int tx_done_c [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
        for (int i = 0; i < 3; i++) exp_q.push_back(make_frame(bytes[i], 1'b0));
        fork
            begin
                logic [10:0] bits;
                int s, d;
                for (int i = 0; i < 3; i++) begin
                    recv_frame(0, bits, s, d);
                    rx_start[i] = s;
                    check_frame("b2b", bits);
                end
            end
            begin
                int k;
                for (int j = 0; j < 3; j++) begin
                    drive(0, bytes[j], 1'b1, 1'b1);
                    tick();
                    drive(0, bytes[j], 1'b0, 1'b1);
                    k = 0;
                    while (bus1.tx_done !== 1'b1 && k < 300) begin tick(); k++; end
                    tx_done_c[j] = (bus1.tx_done === 1'b1) ? cyc : -1;
                end
            end
        join
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rx_start[i+1] - tx_done_c[i] !== 1) begin
                failures++;
                $display("FAIL b2b_gap%0d: next start %0d cycles after done expected 1",
                         i, rx_start[i+1] - tx_done_c[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        bit bad;
        drive(0, 8'h81, 1'b1, 1'b1);
        tick();
        drive(0, 8'h81, 1'b0, 1'b1);
        repeat (50) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: line=%b busy=%b expected line=1 busy=0", bus1.dataout_tx, bus1.tx_busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus1.dataout_tx !== 1'b1 || bus1.tx_busy !== 1'b0 || bus1.tx_done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_stays_idle: activity after reset release, expected idle");
        end
    endtask

    initial begin
        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_even_parity();
        test_odd_parity();
        test_deferred_send();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
